// File: rtl/vga_text_pkg.sv
// Shared constants, character codes and state encoding for the text-mode VRAM writer.
// row_base() gives the first cell address of a row using shifts only (row*80 = row*64 + row*16).
package vga_text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 60;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned DATA_W = 11;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_SCREEN
  } state_e;

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
    logic [ADDR_W-1:0] r;
    r = {{(ADDR_W - ROW_W){1'b0}}, row};
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/vram_fill_counter.sv
// Emits a run of consecutive write strobes base..base+length-1, one per cycle.
// we/addr are combinational so the owner can register them alongside its own writes.
module vram_fill_counter
  import vga_text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              done
);

  logic              active_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remain_q;

  // The start cycle itself issues the first write, so only length-1 remain afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
    end else if (start) begin
      addr_q   <= base + ADDR_W'(1);
      remain_q <= length - ADDR_W'(1);
      active_q <= (length > ADDR_W'(1));
    end else if (active_q) begin
      addr_q   <= addr_q + ADDR_W'(1);
      remain_q <= remain_q - ADDR_W'(1);
      if (remain_q == ADDR_W'(1)) begin
        active_q <= 1'b0;
      end
    end
  end

  assign we   = start | active_q;
  assign addr = start ? base : addr_q;
  assign done = ~active_q;

endmodule

// File: rtl/vram_console_writer.sv
// Console writer for the 80x60 text VRAM: decodes a byte stream, tracks the cursor and
// issues registered VRAM writes; line and screen clears are delegated to vram_fill_counter.
module vram_console_writer
  import vga_text_pkg::*;
#(
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  input  logic [2:0]        char_color,
  output logic              char_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic              busy
);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [DATA_W-1:0] BLANK    = {BG_COLOR, 1'b0, 7'h20};

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pend_q, pend_d;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              newline;
  logic              char_we;
  logic [ADDR_W-1:0] char_addr;
  logic [DATA_W-1:0] char_wdata;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_len;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_we;
  logic              fill_done;

  vram_fill_counter u_fill (
    .clk    (clk),
    .rst    (rst),
    .start  (fill_start),
    .base   (fill_base),
    .length (fill_len),
    .addr   (fill_addr),
    .we     (fill_we),
    .done   (fill_done)
  );

  assign char_ready = (state_q == IDLE);
  assign accept     = char_valid & char_ready;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pend_d     = pend_q;
    newline    = 1'b0;
    char_we    = 1'b0;
    char_addr  = '0;
    char_wdata = '0;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_len   = ADDR_W'(COLS);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (char_data >= CH_SP && char_data <= 8'h7E) begin
            char_we    = 1'b1;
            char_addr  = row_base(row_q) + {{(ADDR_W - COL_W){1'b0}}, col_q};
            char_wdata = {char_color, 1'b0, char_data[6:0]};
            if (col_q == COL_LAST) begin
              newline = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (char_data == CH_LF || char_data == CH_CR) begin
            newline = 1'b1;
          end else if (char_data == CH_BS) begin
            if (col_q != '0) begin
              col_d      = col_q - COL_W'(1);
              char_we    = 1'b1;
              char_addr  = row_base(row_q) + {{(ADDR_W - COL_W){1'b0}}, col_d};
              char_wdata = BLANK;
            end else if (row_q != '0) begin
              row_d      = row_q - ROW_W'(1);
              col_d      = COL_LAST;
              char_we    = 1'b1;
              char_addr  = row_base(row_d) + ADDR_W'(COLS - 1);
              char_wdata = BLANK;
            end
          end else if (char_data == CH_FF) begin
            row_d      = '0;
            col_d      = '0;
            state_d    = CLR_SCREEN;
            fill_start = 1'b1;
            fill_len   = ADDR_W'(CELLS);
          end
        end
      end
      CLR_LINE, CLR_SCREEN: begin
        // A clear requested together with a character write starts one cycle late.
        if (pend_q) begin
          pend_d     = 1'b0;
          fill_start = 1'b1;
          fill_base  = row_base(row_q);
          fill_len   = (state_q == CLR_LINE) ? ADDR_W'(COLS) : ADDR_W'(CELLS);
        end else if (fill_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (newline) begin
      col_d = '0;
      if (row_q == ROW_LAST) begin
        row_d   = '0;
        state_d = CLR_LINE;
        if (char_we) begin
          pend_d = 1'b1;
        end else begin
          fill_start = 1'b1;
        end
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_comb begin
    wr_en   = char_we | fill_we;
    wr_addr = fill_we ? fill_addr : char_addr;
    wr_data = fill_we ? BLANK : char_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pend_q  <= pend_d;
      we_q    <= wr_en;
      if (wr_en) begin
        waddr_q <= wr_addr;
        wdata_q <= wr_data;
      end
    end
  end

  assign vram_we    = we_q;
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vram_console_writer.sv
// Bench for vram_console_writer: a byte table with expected cursor/write results, plus
// hand-written clear, wrap, reset-abort and back-to-back sequences checked via a write queue.
module tb_vram_console_writer;
  import vga_text_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [2:0]  char_color;
  logic        char_ready;
  logic        vram_we;
  logic [12:0] vram_waddr;
  logic [10:0] vram_wdata;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  vram_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_color (char_color),
    .char_ready (char_ready),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] addr;
    logic [10:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  d;
    logic [2:0]  c;
    bit          we;
    logic [12:0] a;
    logic [10:0] w;
    int          row;
    int          col;
  } vec_t;

  localparam logic [10:0] BLANK_W = 11'h020;

  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   wr_seen = 0;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [12:0] a, input logic [10:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard side: every write seen on the port must match the head of the queue.
  task automatic monitor();
    wr_t e;
    if (!rst && vram_we) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected write: addr %0d data %0h, none expected", vram_waddr,
                 vram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write addr", 32'(vram_waddr), 32'(e.addr));
        check("write data", 32'(vram_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] c);
    int n;
    n = 0;
    while (!char_ready && n < 10000) begin
      tick();
      n++;
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL ready timeout: char_ready %0b after %0d cycles, required 1", char_ready, n);
    end
    char_valid = 1'b1;
    char_data  = d;
    char_color = c;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, " row"}, 32'(cursor_row), 32'(row));
    check({name, " col"}, 32'(cursor_col), 32'(col));
  endtask

  initial begin
    int  n;
    int  w0;
    int  rdy_bad;
    time t0;

    vecs[0]  = '{8'h41, 3'd5, 1'b1, 13'd0,   11'h541, 0, 1};
    vecs[1]  = '{8'h07, 3'd0, 1'b0, 13'd0,   11'h000, 0, 1};
    vecs[2]  = '{8'h42, 3'd2, 1'b1, 13'd1,   11'h242, 0, 2};
    vecs[3]  = '{8'h0D, 3'd0, 1'b0, 13'd0,   11'h000, 1, 0};
    vecs[4]  = '{8'h08, 3'd0, 1'b1, 13'd79,  BLANK_W, 0, 79};
    vecs[5]  = '{8'h08, 3'd0, 1'b1, 13'd78,  BLANK_W, 0, 78};
    vecs[6]  = '{8'h7A, 3'd7, 1'b1, 13'd78,  11'h77A, 0, 79};
    vecs[7]  = '{8'h5A, 3'd4, 1'b1, 13'd79,  11'h45A, 1, 0};
    vecs[8]  = '{8'h5A, 3'd4, 1'b1, 13'd80,  11'h45A, 1, 1};
    vecs[9]  = '{8'h08, 3'd0, 1'b1, 13'd80,  BLANK_W, 1, 0};
    vecs[10] = '{8'h0A, 3'd0, 1'b0, 13'd0,   11'h000, 2, 0};
    vecs[11] = '{8'h08, 3'd0, 1'b1, 13'd159, BLANK_W, 1, 79};
    vecs[12] = '{8'h7E, 3'd1, 1'b1, 13'd159, 11'h17E, 2, 0};
    vecs[13] = '{8'h7F, 3'd3, 1'b0, 13'd0,   11'h000, 2, 0};
    vecs[14] = '{8'h1F, 3'd3, 1'b0, 13'd0,   11'h000, 2, 0};
    vecs[15] = '{8'hC1, 3'd5, 1'b0, 13'd0,   11'h000, 2, 0};
    vecs[16] = '{8'h20, 3'd6, 1'b1, 13'd160, 11'h620, 2, 1};

    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    char_color = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(char_ready), 32'd1);
    check("reset we", 32'(vram_we), 32'd0);
    check("reset waddr", 32'(vram_waddr), 32'd0);
    check("reset wdata", 32'(vram_wdata), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check_cursor("reset", 0, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we) push(vecs[i].a, vecs[i].w);
      send(vecs[i].d, vecs[i].c);
      check($sformatf("vec%0d we", i), 32'(vram_we), 32'(vecs[i].we));
      check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
    end
    tick();

    // Full-screen clear.
    for (int a = 0; a < 4800; a++) push(13'(a), BLANK_W);
    send(CH_FF, 3'd0);
    check_cursor("ff", 0, 0);
    check("ff busy", 32'(busy), 32'd1);
    n = 0;
    rdy_bad = 0;
    while (busy && n < 6000) begin
      if (char_ready) rdy_bad++;
      tick();
      n++;
    end
    check("ff busy cycles", 32'(n), 32'd4800);
    check("ff ready during clear", 32'(rdy_bad), 32'd0);
    check("ff queue drained", 32'(exp_q.size()), 32'd0);
    check("ff ready after", 32'(char_ready), 32'd1);

    // Newline on the last row at 59/10 clears line 0.
    for (int r = 0; r < 59; r++) send(CH_LF, 3'd0);
    for (int c = 0; c < 10; c++) begin
      push(13'(4720 + c), 11'h341);
      send(8'h41, 3'd3);
    end
    check_cursor("at 59/10", 59, 10);
    for (int a = 0; a < 80; a++) push(13'(a), BLANK_W);
    send(CH_LF, 3'd0);
    w0 = wr_seen;
    check_cursor("lf wrap", 0, 0);
    check("lf wrap busy", 32'(busy), 32'd1);
    check("lf wrap ready", 32'(char_ready), 32'd0);
    n = 0;
    rdy_bad = 0;
    while (busy && n < 300) begin
      if (char_ready) rdy_bad++;
      tick();
      n++;
    end
    check("lf clear cycles", 32'(n), 32'd80);
    check("lf clear writes", 32'(wr_seen - w0), 32'd80);
    check("lf ready during clear", 32'(rdy_bad), 32'd0);
    check("lf queue drained", 32'(exp_q.size()), 32'd0);
    check("lf ready after", 32'(char_ready), 32'd1);
    check("lf we after", 32'(vram_we), 32'd0);

    // Printable at 59/79: the character lands at 4799, then line 0 is cleared.
    for (int r = 0; r < 59; r++) send(CH_LF, 3'd0);
    for (int c = 0; c < 79; c++) begin
      push(13'(4720 + c), 11'h078);
      send(8'h78, 3'd0);
    end
    push(13'd4799, 11'h251);
    for (int a = 0; a < 80; a++) push(13'(a), BLANK_W);
    send(8'h51, 3'd2);
    check_cursor("char wrap", 0, 0);
    check("char wrap busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    tick();
    check("char wrap busy ends", 32'(busy), 32'd0);
    check("char wrap queue drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a full-screen clear.
    push(13'd0, 11'h041);
    send(8'h41, 3'd0);
    tick();
    for (int a = 0; a < 4800; a++) push(13'(a), BLANK_W);
    send(CH_FF, 3'd0);
    w0 = wr_seen;
    n = 0;
    while ((wr_seen - w0) < 1000 && n < 3000) begin
      tick();
      n++;
    end
    check("abort writes before reset", 32'(wr_seen - w0), 32'd1000);
    rst = 1'b1;
    #1;
    check("abort we", 32'(vram_we), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check_cursor("abort", 0, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    w0 = wr_seen;
    repeat (20) tick();
    check("abort no writes after release", 32'(wr_seen - w0), 32'd0);
    check("abort ready", 32'(char_ready), 32'd1);

    // Backspace at home does nothing.
    send(CH_BS, 3'd0);
    check("bs home we", 32'(vram_we), 32'd0);
    check_cursor("bs home", 0, 0);

    // Back-to-back printables, one accepted per cycle.
    t0 = $time;
    for (int k = 0; k < 4; k++) begin
      push(13'(k), {3'd1, 1'b0, 7'(8'h41 + k)});
      send(8'(8'h41 + k), 3'd1);
      check($sformatf("b2b%0d we", k), 32'(vram_we), 32'd1);
    end
    check("b2b cycles", 32'($time - t0), 32'd40);
    send(8'h07, 3'd1);
    check("bel we", 32'(vram_we), 32'd0);
    check_cursor("bel", 0, 4);

    repeat (10) tick();
    check("final queue drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
